// File: rtl/edge_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// edge_arb_pkg : shared arbiter state type and default sizing  (rev 1.0)
// ============================================================================
package edge_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_DIV_W = 8;

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// edge_event_arbiter_if : valid/ready event channel  (rev 1.0)
// ============================================================================
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (output evt_valid, output evt_ch, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, output evt_ready);

endinterface
`default_nettype wire

// File: rtl/edge_event_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin selector, search starts after 'last'
// rev 1.0
// ============================================================================
module rr_pick
  import edge_arb_pkg::*;
#(
  parameter int  N_CH = DEF_N_CH,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = (int'(last) + k) % N_CH;
      if (!found && req[cand]) begin
        idx   = CH_W'(cand);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// edge_event_arbiter : tick-sampled rising-edge detector feeding a shared
// round-robin valid/ready event channel  (rev 1.0)
// ============================================================================
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int  N_CH  = DEF_N_CH,
  parameter int  DIV_W = DEF_DIV_W,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            signal_in,
  edge_event_arbiter_if.master       evt,
  output logic [N_CH-1:0]            pending_o,
  output logic [N_CH-1:0]            overrun_o,
  input  logic                       overrun_clr
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  sample_q, sample_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic [N_CH-1:0]  rise, clr;
  logic             tick, accept;

  arb_state_t       state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic             pick_any;
  logic [CH_W-1:0]  pick_idx;

  always_comb begin
    div_d    = div_q + DIV_W'(1);
    tick     = &div_q;
    rise     = tick ? (sync2_q & ~sample_q) : '0;
    sample_d = tick ? sync2_q : sample_q;
    accept   = evt_valid_q & evt.evt_ready;
    clr      = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr[i] = accept && (int'(evt_ch_q) == i);
    end
    // A new rise overrides a same-cycle clear, and only counts as an overrun
    // when the old event is not being consumed right now.
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = (overrun_clr ? '0 : overrun_q) | (rise & pending_q & ~clr);
  end

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req  (pending_q),
    .last (last_grant_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          evt_ch_d    = pick_idx;
          evt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          evt_valid_d  = 1'b0;
          last_grant_d = evt_ch_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_q     <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
    end else begin
      div_q        <= div_d;
      sync1_q      <= signal_in;
      sync2_q      <= sync1_q;
      sample_q     <= sample_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ch    = evt_ch_q;
  assign pending_o     = pending_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// tb_edge_event_arbiter : scenario tasks plus randomized traffic against a
// cycle-level behavioural model of the edge/event rules  (rev 1.0)
// ============================================================================
module tb_edge_event_arbiter;

  localparam int N     = 4;
  localparam int DIV_W = 2;
  localparam int P     = 4;
  localparam int CH_W  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  signal_in = '0;
  logic          overrun_clr = 1'b0;
  logic [N-1:0]  pending_o, overrun_o;

  edge_event_arbiter_if #(.CH_W(CH_W)) evt_bus ();

  edge_event_arbiter #(.N_CH(N), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal_in   (signal_in),
    .evt         (evt_bus),
    .pending_o   (pending_o),
    .overrun_o   (overrun_o),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_q[$];

  // Reference state: sync pipeline, last tick sample, pending/overrun sets,
  // the offered event (if any) and the last granted channel.
  logic [N-1:0]    m_s1, m_s2, m_samp, m_pend, m_ovr;
  logic            m_valid;
  logic [CH_W-1:0] m_ch, m_last;
  int              m_cnt;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_samp = '0; m_pend = '0; m_ovr = '0;
    m_valid = 1'b0; m_ch = '0; m_last = CH_W'(N - 1); m_cnt = 0;
  endtask

  task automatic model_step();
    bit tick, acc, rose, taken;
    int c;
    logic [N-1:0] pend_n, ovr_n;
    tick   = (m_cnt % P) == (P - 1);
    acc    = m_valid && evt_bus.evt_ready;
    pend_n = m_pend;
    ovr_n  = overrun_clr ? '0 : m_ovr;
    for (int i = 0; i < N; i++) begin
      rose  = tick && m_s2[i] && !m_samp[i];
      taken = acc && (int'(m_ch) == i);
      if (rose) begin
        if (m_pend[i] && !taken) ovr_n[i] = 1'b1;
        pend_n[i] = 1'b1;
      end else if (taken) begin
        pend_n[i] = 1'b0;
      end
    end
    if (!m_valid) begin
      for (int k = 1; k <= N; k++) begin
        c = (int'(m_last) + k) % N;
        if (m_pend[c] && !m_valid) begin
          m_ch = CH_W'(c);
          m_valid = 1'b1;
        end
      end
    end else if (acc) begin
      m_valid = 1'b0;
      m_last  = m_ch;
    end
    if (tick) m_samp = m_s2;
    m_s2 = m_s1;
    m_s1 = signal_in;
    m_pend = pend_n;
    m_ovr  = ovr_n;
    m_cnt++;
  endtask

  // Advance one clock; log consumer-side accepts seen on the bus.
  task automatic cycle();
    if (evt_bus.evt_valid && evt_bus.evt_ready) acc_q.push_back(int'(evt_bus.evt_ch));
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; signal_in = '1; evt_bus.evt_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    n_cmp++;
    if ({evt_bus.evt_valid, pending_o, overrun_o} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0b pend=%b ovr=%b, want all zero",
               evt_bus.evt_valid, pending_o, overrun_o);
    end
    rst_n = 1'b1;
    evt_bus.evt_ready = 1'b1;
    acc_q.delete();
    repeat (16) begin
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL reset_release: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    n_cmp++;
    if (acc_q.size() != 4 || acc_q[0] != 0 || acc_q[1] != 1 || acc_q[2] != 2 || acc_q[3] != 3) begin
      n_bad++;
      $display("FAIL reset_order: got %p, want 0,1,2,3", acc_q);
    end
  endtask

  task automatic test_single_edge();
    signal_in = '0; evt_bus.evt_ready = 1'b1;
    repeat (8) cycle();
    acc_q.delete();
    signal_in[2] = 1'b1;
    repeat (24) begin
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL single_edge: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    n_cmp++;
    if (acc_q.size() != 1 || acc_q[0] != 2 || pending_o[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_edge_count: got events %p pend2=%b, want one event on ch2 pend2=0",
               acc_q, pending_o[2]);
    end
  endtask

  task automatic test_backpressure();
    int waited;
    signal_in = '0; evt_bus.evt_ready = 1'b1;
    repeat (8) cycle();
    evt_bus.evt_ready = 1'b0;
    signal_in = 4'b1010;
    waited = 0;
    while (!m_valid && waited < 20) begin
      cycle();
      waited++;
    end
    n_cmp++;
    if (!m_valid || evt_bus.evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_offer: got v=%0b, want 1 within 20 clk", evt_bus.evt_valid);
    end
    repeat (10) begin
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL bp_hold: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    acc_q.delete();
    evt_bus.evt_ready = 1'b1;
    repeat (6) cycle();
    // Last grant was ch2, so ch3 wins over ch1.
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0] != 3 || acc_q[1] != 1) begin
      n_bad++;
      $display("FAIL bp_order: got %p, want 3,1", acc_q);
    end
  endtask

  task automatic test_round_robin();
    signal_in = '0; evt_bus.evt_ready = 1'b1;
    repeat (8) cycle();
    acc_q.delete();
    signal_in = 4'b0101;
    repeat (16) begin
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL rr_model: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0] != 2 || acc_q[1] != 0) begin
      n_bad++;
      $display("FAIL rr_order_a: got %p, want 2,0", acc_q);
    end
    signal_in = '0;
    repeat (8) cycle();
    acc_q.delete();
    signal_in = 4'b1001;
    repeat (16) cycle();
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0] != 3 || acc_q[1] != 0) begin
      n_bad++;
      $display("FAIL rr_order_b: got %p, want 3,0", acc_q);
    end
  endtask

  task automatic test_overrun();
    signal_in = '0; evt_bus.evt_ready = 1'b1;
    repeat (8) cycle();
    evt_bus.evt_ready = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      signal_in[1] = (ph != 1);
      repeat (8) begin
        cycle();
        n_cmp++;
        if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
          n_bad++;
          $display("FAIL overrun_model: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                   evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
        end
      end
    end
    n_cmp++;
    if (overrun_o !== 4'b0010 || pending_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL overrun_set: got ovr=%b pend=%b, want ovr=0010 pend=0010", overrun_o, pending_o);
    end
    overrun_clr = 1'b1;
    cycle();
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun_o !== 4'b0000 || pending_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL overrun_clear: got ovr=%b pend=%b, want ovr=0000 pend=0010", overrun_o, pending_o);
    end
  endtask

  task automatic test_async_reset();
    n_cmp++;
    if (evt_bus.evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre: got v=%0b, want 1", evt_bus.evt_valid);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({evt_bus.evt_valid, pending_o, overrun_o} !== 9'b0) begin
      n_bad++;
      $display("FAIL areset_now: got v=%0b pend=%b ovr=%b, want all zero",
               evt_bus.evt_valid, pending_o, overrun_o);
    end
    signal_in = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    evt_bus.evt_ready = 1'b1;
    acc_q.delete();
    repeat (12) begin
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL areset_after: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    n_cmp++;
    if (acc_q.size() != 0) begin
      n_bad++;
      $display("FAIL areset_stale: got %0d events, want 0", acc_q.size());
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) signal_in[$urandom_range(0, N - 1)] ^= 1'b1;
      evt_bus.evt_ready = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      cycle();
      n_cmp++;
      if ({evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o} !== {m_valid, m_ch, m_pend, m_ovr}) begin
        n_bad++;
        $display("FAIL random: got v=%0b ch=%0d pend=%b ovr=%b, want v=%0b ch=%0d pend=%b ovr=%b",
                 evt_bus.evt_valid, evt_bus.evt_ch, pending_o, overrun_o, m_valid, m_ch, m_pend, m_ovr);
      end
    end
    overrun_clr = 1'b0;
  endtask

  initial begin
    evt_bus.evt_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_edge();
    test_backpressure();
    test_round_robin();
    test_overrun();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
